// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide engine owning the HI/LO pair.
// One op per Start; WIDTH+1 busy cycles; result committed on leaving FIX.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] HI_out,
    output logic [WIDTH-1:0] LO_out
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_DIVU = 3'd3;
    localparam logic [2:0] OP_MADD = 3'd4;
    localparam logic [2:0] OP_MSUB = 3'd5;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_q;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_divz;
    logic               r_done;

    logic               w_is_mt;
    logic               w_is_div;
    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic               w_load;
    logic               w_commit;
    logic               w_move;
    logic               w_run_div;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_sprod;
    logic [2*WIDTH-1:0] w_acc;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_remd;

    assign w_is_mt  = Op[2] & Op[1];
    assign w_is_div = (Op == OP_DIV) | (Op == OP_DIVU);
    assign w_signed = (Op == OP_MULT) | (Op == OP_DIV)
                    | (Op == OP_MADD) | (Op == OP_MSUB);
    assign w_sa     = w_signed & A[WIDTH-1];
    assign w_sb     = w_signed & B[WIDTH-1];
    assign w_abs_a  = w_sa ? -A : A;
    assign w_abs_b  = w_sb ? -B : B;
    assign w_move   = (r_state == S_IDLE) & Start & ~Flush & w_is_mt;
    assign w_run_div = (r_op == OP_DIV) | (r_op == OP_DIVU);

    assign Busy   = (r_state != S_IDLE);
    assign Stall  = Busy | (Start & ~w_is_mt);
    assign Done   = r_done;
    assign HI_out = r_hi;
    assign LO_out = r_lo;

    // Multiply: {rem,q} is the product shift register, q starting as |B|.
    // Divide: q shifts the dividend out and the quotient bits in.
    assign w_sum   = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_mag} : '0);
    assign w_trial = {r_rem, r_q[WIDTH-1]} - {1'b0, r_mag};

    assign w_prod  = {r_rem, r_q};
    assign w_sprod = r_neg_q ? -w_prod : w_prod;
    assign w_quot  = r_divz ? '1 : (r_neg_q ? -r_q : r_q);
    assign w_remd  = r_neg_r ? -r_rem : r_rem;

    always_comb begin
        w_acc = w_sprod;
        if (r_op == OP_MADD) begin
            w_acc = {r_hi, r_lo} + w_sprod;
        end else if (r_op == OP_MSUB) begin
            w_acc = {r_hi, r_lo} - w_sprod;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start && !Flush && !w_is_mt) begin
                    w_next = S_RUN;
                    w_load = 1'b1;
                end
            end
            S_RUN: begin
                if (Flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_ONE) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next   = S_IDLE;
                w_commit = ~Flush;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_mag   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_divz  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_load) begin
                r_op    <= Op;
                r_cnt   <= CNT_W'(WIDTH);
                r_neg_q <= w_sa ^ w_sb;
                r_neg_r <= w_sa;
                r_divz  <= (B == '0);
                r_rem   <= '0;
                r_mag   <= w_is_div ? w_abs_b : w_abs_a;
                r_q     <= w_is_div ? w_abs_a : w_abs_b;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - CNT_ONE;
                if (w_run_div) begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    r_rem <= w_sum[WIDTH:1];
                    r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                end
            end
            if (w_move) begin
                if (Op[0]) begin
                    r_lo <= A;
                end else begin
                    r_hi <= A;
                end
            end else if (w_commit) begin
                if (w_run_div) begin
                    r_hi <= w_remd;
                    r_lo <= w_quot;
                end else begin
                    {r_hi, r_lo} <= w_acc;
                end
            end
        end
    end
endmodule
